// File: rtl/hop_cnt_rr_arbiter_if.sv
// rtl/hop_cnt_rr_arbiter_if.sv - request/grant bundle between input buffers and the hop-count arbiter
interface hop_cnt_rr_arbiter_if #(
   parameter int IN_N      = 5,
   parameter int HOP_CNT_W = 3
);
   localparam int IDX_W = $clog2(IN_N);

   logic [IN_N-1:0]                req_i;
   logic [IN_N-1:0][HOP_CNT_W-1:0] hop_cnt_i;
   logic [IN_N-1:0]                last_i;
   logic                           ready_i;
   logic [IN_N-1:0]                gnt_o;
   logic                           gnt_vld_o;
   logic [IDX_W-1:0]               gnt_idx_o;
   logic                           tie_o;

   modport master (
      output req_i, hop_cnt_i, last_i, ready_i,
      input  gnt_o, gnt_vld_o, gnt_idx_o, tie_o
   );

   modport slave (
      input  req_i, hop_cnt_i, last_i, ready_i,
      output gnt_o, gnt_vld_o, gnt_idx_o, tie_o
   );
endinterface

// File: rtl/hop_cnt_rr_arbiter.sv
// rtl/hop_cnt_rr_arbiter.sv - highest-hop-count arbiter with round-robin tie break and packet locking
// Define HOP_ARB_AGING_EN to add saturating per-input age counters for starvation protection.
module hop_cnt_rr_arbiter #(
   parameter int IN_N      = 5,
   parameter int HOP_CNT_W = 3,
   parameter int AGE_W     = 4
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   hop_cnt_rr_arbiter_if.slave arb
);
   localparam int IDX_W = $clog2(IN_N);
   localparam int CNT_W = $clog2(IN_N + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IN_N - 1);

   if (IN_N < 2 || HOP_CNT_W < 1 || AGE_W < 1) begin : g_bad_params
      $error("hop_cnt_rr_arbiter: IN_N must be >= 2, HOP_CNT_W and AGE_W >= 1");
   end

   typedef enum logic {IDLE, LOCKED} state_e;

   state_e                         state_q;
   logic [IN_N-1:0]                gnt_q;
   logic                           gnt_vld_q;
   logic [IDX_W-1:0]               gnt_idx_q;
   logic                           tie_q;
   logic [IDX_W-1:0]               rr_ptr_q;

   logic [IN_N-1:0][HOP_CNT_W-1:0] hop_m;
   logic [HOP_CNT_W-1:0]           max_hop;
   logic [IN_N-1:0]                cand;
   logic [IN_N-1:0]                sel;
   logic [IDX_W-1:0]               win_d;
   logic [CNT_W-1:0]               sel_cnt;
   logic                           tie_d;
   logic                           found;
   int                             scan_idx;
   logic                           xfer_last;

   always_comb begin
      max_hop = '0;
      for (int i = 0; i < IN_N; i++) begin
         hop_m[i] = arb.req_i[i] ? arb.hop_cnt_i[i] : '0;
         if (hop_m[i] > max_hop) max_hop = hop_m[i];
      end
      for (int i = 0; i < IN_N; i++) begin
         cand[i] = arb.req_i[i] && (hop_m[i] == max_hop);
      end
   end

`ifdef HOP_ARB_AGING_EN
   localparam logic [AGE_W-1:0] AGE_MAX = '1;

   logic [IN_N-1:0][AGE_W-1:0] age_q;
   logic [IN_N-1:0]            aged;

   always_comb begin
      for (int i = 0; i < IN_N; i++) begin
         aged[i] = arb.req_i[i] && (age_q[i] == AGE_MAX);
      end
   end

   // Starved inputs override hop-count priority entirely.
   assign sel = (|aged) ? aged : cand;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         age_q <= '0;
      end else begin
         for (int i = 0; i < IN_N; i++) begin
            if (!arb.req_i[i]) begin
               age_q[i] <= '0;
            end else if (state_q == IDLE) begin
               if (IDX_W'(i) == win_d) age_q[i] <= '0;
               else if (age_q[i] != AGE_MAX) age_q[i] <= age_q[i] + 1'b1;
            end
         end
      end
   end
`else
   assign sel = cand;
`endif

   always_comb begin
      win_d    = '0;
      found    = 1'b0;
      scan_idx = 0;
      sel_cnt  = '0;
      for (int k = 0; k < IN_N; k++) begin
         scan_idx = (int'(rr_ptr_q) + k) % IN_N;
         if (!found && sel[scan_idx]) begin
            win_d = IDX_W'(scan_idx);
            found = 1'b1;
         end
         sel_cnt = sel_cnt + CNT_W'(sel[k]);
      end
      tie_d = (sel_cnt > CNT_W'(1));
   end

   assign xfer_last = arb.req_i[gnt_idx_q] & arb.ready_i & arb.last_i[gnt_idx_q];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         gnt_q     <= '0;
         gnt_vld_q <= 1'b0;
         gnt_idx_q <= '0;
         tie_q     <= 1'b0;
         rr_ptr_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (|arb.req_i) begin
                  gnt_q     <= IN_N'(1) << win_d;
                  gnt_idx_q <= win_d;
                  gnt_vld_q <= 1'b1;
                  tie_q     <= tie_d;
                  state_q   <= LOCKED;
               end
            end
            LOCKED: begin
               // Only the tail flit of the owning input releases the lock.
               if (xfer_last) begin
                  gnt_q     <= '0;
                  gnt_vld_q <= 1'b0;
                  rr_ptr_q  <= (gnt_idx_q == LAST_IDX) ? '0 : gnt_idx_q + 1'b1;
                  state_q   <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign arb.gnt_o     = gnt_q;
   assign arb.gnt_vld_o = gnt_vld_q;
   assign arb.gnt_idx_o = gnt_idx_q;
   assign arb.tie_o     = tie_q;
endmodule

// File: tb/tb_hop_cnt_rr_arbiter.sv
// tb/tb_hop_cnt_rr_arbiter.sv - self-checking bench for hop_cnt_rr_arbiter (directed plus random vs model)
module tb_hop_cnt_rr_arbiter;
   localparam int N       = 5;
   localparam int W       = 3;
   localparam int AW      = 2;
   localparam int AGE_MAX = 3;

   typedef logic [N-1:0][W-1:0] hop_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   hop_cnt_rr_arbiter_if #(.IN_N(N), .HOP_CNT_W(W)) bus ();

   hop_cnt_rr_arbiter #(.IN_N(N), .HOP_CNT_W(W), .AGE_W(AW)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .arb    (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: packet owner, pointer and ages as plain integers.
   bit m_locked;
   int m_owner;
   int m_ptr;
   bit m_tie;
   int m_age[N];

   function automatic hop_t mk_hop(int h4, int h3, int h2, int h1, int h0);
      hop_t h;
      h[4] = W'(h4); h[3] = W'(h3); h[2] = W'(h2); h[1] = W'(h1); h[0] = W'(h0);
      return h;
   endfunction

   task automatic model_reset();
      m_locked = 0; m_owner = 0; m_ptr = 0; m_tie = 0;
      for (int i = 0; i < N; i++) m_age[i] = 0;
   endtask

   task automatic model_update(input logic [N-1:0] r, input hop_t h, input logic [N-1:0] l, input logic rd);
      int q[$];
      int mx;
      int win;
      bit arb_now;
      arb_now = !m_locked && (r != '0);
      win = -1;
      if (arb_now) begin
         mx = 0;
         for (int i = 0; i < N; i++) if (r[i] && int'(h[i]) > mx) mx = int'(h[i]);
         for (int i = 0; i < N; i++) if (r[i] && int'(h[i]) == mx) q.push_back(i);
`ifdef HOP_ARB_AGING_EN
         begin
            int aq[$];
            for (int i = 0; i < N; i++) if (r[i] && m_age[i] == AGE_MAX) aq.push_back(i);
            if (aq.size() > 0) q = aq;
         end
`endif
         win = q[0];
         for (int j = q.size() - 1; j >= 0; j--) if (q[j] >= m_ptr) win = q[j];
         m_owner  = win;
         m_tie    = q.size() > 1;
         m_locked = 1;
      end else if (m_locked && r[m_owner] && rd && l[m_owner]) begin
         m_locked = 0;
         m_ptr    = (m_owner + 1) % N;
      end
      for (int i = 0; i < N; i++) begin
         if (!r[i]) m_age[i] = 0;
         else if (arb_now) m_age[i] = (i == win) ? 0 : ((m_age[i] < AGE_MAX) ? m_age[i] + 1 : AGE_MAX);
      end
   endtask

   task automatic step(input logic [N-1:0] r, input hop_t h, input logic [N-1:0] l, input logic rd);
      bus.req_i     = r;
      bus.hop_cnt_i = h;
      bus.last_i    = l;
      bus.ready_i   = rd;
      model_update(r, h, l, rd);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n         = 1'b0;
      bus.req_i     = '0;
      bus.hop_cnt_i = '0;
      bus.last_i    = '0;
      bus.ready_i   = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if ({bus.gnt_vld_o, bus.gnt_o, bus.gnt_idx_o, bus.tie_o} !== 10'b0) begin
         n_fail++;
         $display("FAIL reset_state vld/gnt/idx/tie got %b/%b/%0d/%b want 0/00000/0/0",
                  bus.gnt_vld_o, bus.gnt_o, bus.gnt_idx_o, bus.tie_o);
      end
   endtask

   task automatic test_highest_hop();
      hop_t h;
      do_reset();
      h = mk_hop(3, 0, 6, 2, 0);
      bus.req_i = 5'b10110; bus.hop_cnt_i = h;
      #1;
      n_checks++;
      if (bus.gnt_vld_o !== 1'b0) begin
         n_fail++; $display("FAIL latency_no_comb_grant vld got %b want 0", bus.gnt_vld_o);
      end
      step(5'b10110, h, 5'b00000, 1'b0);
      n_checks++;
      if ({bus.gnt_vld_o, bus.gnt_o, bus.gnt_idx_o, bus.tie_o} !== {1'b1, 5'b00100, 3'd2, 1'b0}) begin
         n_fail++;
         $display("FAIL highest_hop vld/gnt/idx/tie got %b/%b/%0d/%b want 1/00100/2/0",
                  bus.gnt_vld_o, bus.gnt_o, bus.gnt_idx_o, bus.tie_o);
      end
      step(5'b10110, h, 5'b00100, 1'b1);
      n_checks++;
      if ({bus.gnt_vld_o, bus.gnt_o} !== 6'b0) begin
         n_fail++; $display("FAIL single_flit_release vld/gnt got %b/%b want 0/00000", bus.gnt_vld_o, bus.gnt_o);
      end
   endtask

   task automatic test_tie_rr();
      hop_t h;
      do_reset();
      h = mk_hop(0, 5, 0, 5, 0);
      step(5'b01010, h, 5'b01010, 1'b1);
      n_checks++;
      if ({bus.gnt_o, bus.gnt_idx_o, bus.tie_o} !== {5'b00010, 3'd1, 1'b1}) begin
         n_fail++; $display("FAIL tie_first gnt/idx/tie got %b/%0d/%b want 00010/1/1", bus.gnt_o, bus.gnt_idx_o, bus.tie_o);
      end
      step(5'b01010, h, 5'b01010, 1'b1);
      n_checks++;
      if ({bus.gnt_vld_o, bus.tie_o} !== 2'b01) begin
         n_fail++; $display("FAIL tie_release vld/tie got %b/%b want 0/1", bus.gnt_vld_o, bus.tie_o);
      end
      step(5'b01010, h, 5'b01010, 1'b1);
      n_checks++;
      if ({bus.gnt_o, bus.gnt_idx_o, bus.tie_o} !== {5'b01000, 3'd3, 1'b1}) begin
         n_fail++; $display("FAIL tie_rr_next gnt/idx/tie got %b/%0d/%b want 01000/3/1", bus.gnt_o, bus.gnt_idx_o, bus.tie_o);
      end
   endtask

   task automatic test_locking_and_wrap();
      hop_t h;
      logic rdy_seq [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
      do_reset();
      step(5'b00001, mk_hop(0, 0, 0, 0, 2), 5'b00000, 1'b0);
      for (int c = 0; c < 4; c++) begin
         h = (c >= 2) ? mk_hop(7, 0, 0, 0, 2) : mk_hop(0, 0, 0, 0, 2);
         step((c >= 2) ? 5'b10001 : 5'b00001, h, 5'b00000, rdy_seq[c]);
         n_checks++;
         if ({bus.gnt_vld_o, bus.gnt_o} !== 6'b100001) begin
            n_fail++; $display("FAIL lock_hold cycle %0d vld/gnt got %b/%b want 1/00001", c, bus.gnt_vld_o, bus.gnt_o);
         end
      end
      step(5'b10001, mk_hop(7, 0, 0, 0, 2), 5'b00001, 1'b1);
      n_checks++;
      if ({bus.gnt_vld_o, bus.gnt_o} !== 6'b0) begin
         n_fail++; $display("FAIL lock_tail_bubble vld/gnt got %b/%b want 0/00000", bus.gnt_vld_o, bus.gnt_o);
      end
      h = mk_hop(7, 0, 0, 0, 0);
      step(5'b10000, h, 5'b10000, 1'b1);
      n_checks++;
      if ({bus.gnt_o, bus.gnt_idx_o} !== {5'b10000, 3'd4}) begin
         n_fail++; $display("FAIL lock_then_hi_hop gnt/idx got %b/%0d want 10000/4", bus.gnt_o, bus.gnt_idx_o);
      end
      step(5'b10000, h, 5'b10000, 1'b1);
      for (int c = 0; c < 3; c++) begin
         step(5'b00000, h, 5'b00000, 1'b1);
         n_checks++;
         if (bus.gnt_vld_o !== 1'b0) begin
            n_fail++; $display("FAIL idle_no_grant cycle %0d vld got %b want 0", c, bus.gnt_vld_o);
         end
      end
      step(5'b10001, mk_hop(3, 0, 0, 0, 3), 5'b00000, 1'b0);
      n_checks++;
      if ({bus.gnt_o, bus.gnt_idx_o, bus.tie_o} !== {5'b00001, 3'd0, 1'b1}) begin
         n_fail++; $display("FAIL ptr_wrap gnt/idx/tie got %b/%0d/%b want 00001/0/1", bus.gnt_o, bus.gnt_idx_o, bus.tie_o);
      end
   endtask

   task automatic test_async_reset();
      hop_t h;
      do_reset();
      h = mk_hop(0, 5, 0, 5, 0);
      step(5'b01010, h, 5'b01010, 1'b1);
      step(5'b01010, h, 5'b01010, 1'b1);
      step(5'b01010, h, 5'b00000, 1'b1);
      step(5'b01010, h, 5'b00000, 1'b1);
      n_checks++;
      if (bus.gnt_o !== 5'b01000) begin
         n_fail++; $display("FAIL areset_setup gnt got %b want 01000", bus.gnt_o);
      end
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      n_checks++;
      if ({bus.gnt_vld_o, bus.gnt_o, bus.gnt_idx_o, bus.tie_o} !== 10'b0) begin
         n_fail++;
         $display("FAIL areset_immediate vld/gnt/idx/tie got %b/%b/%0d/%b want 0/00000/0/0",
                  bus.gnt_vld_o, bus.gnt_o, bus.gnt_idx_o, bus.tie_o);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step(5'b01010, h, 5'b01010, 1'b1);
      n_checks++;
      if (bus.gnt_o !== 5'b00010) begin
         n_fail++; $display("FAIL areset_ptr_cleared gnt got %b want 00010", bus.gnt_o);
      end
   endtask

`ifdef HOP_ARB_AGING_EN
   task automatic test_aging();
      hop_t h;
      do_reset();
      h = mk_hop(0, 0, 7, 7, 1);
      for (int a = 1; a <= 5; a++) begin
         step(5'b00111, h, 5'b00111, 1'b1);
         n_checks++;
         if ({bus.gnt_vld_o, bus.gnt_o[0], bus.tie_o} !== {1'b1, (a == 4), (a < 4)}) begin
            n_fail++;
            $display("FAIL aging arb %0d vld/gnt0/tie got %b/%b/%b want 1/%b/%b",
                     a, bus.gnt_vld_o, bus.gnt_o[0], bus.tie_o, (a == 4), (a < 4));
         end
         step(5'b00111, h, 5'b00111, 1'b1);
      end
   endtask
`endif

   task automatic test_random();
      logic [N-1:0] r, l, exp_gnt;
      hop_t h;
      logic rd;
      do_reset();
      for (int c = 0; c < 1500; c++) begin
         r = N'($urandom) | (($urandom_range(0, 3) == 0) ? N'(0) : N'($urandom));
         if ($urandom_range(0, 7) == 0) r = '0;
         for (int i = 0; i < N; i++) begin
            h[i] = $urandom_range(0, 1) ? W'($urandom_range(6, 7)) : W'($urandom_range(0, 7));
            l[i] = ($urandom_range(0, 3) == 0);
         end
         rd = ($urandom_range(0, 3) != 0);
         step(r, h, l, rd);
         exp_gnt = m_locked ? (N'(1) << m_owner) : '0;
         n_checks++;
         if ({bus.gnt_vld_o, bus.gnt_o, bus.gnt_idx_o, bus.tie_o} !== {m_locked, exp_gnt, 3'(m_owner), m_tie}) begin
            n_fail++;
            $display("FAIL random cycle %0d vld/gnt/idx/tie got %b/%b/%0d/%b want %b/%b/%0d/%b",
                     c, bus.gnt_vld_o, bus.gnt_o, bus.gnt_idx_o, bus.tie_o, m_locked, exp_gnt, m_owner, m_tie);
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      test_reset();
      test_highest_hop();
      test_tie_rr();
      test_locking_and_wrap();
      test_async_reset();
`ifdef HOP_ARB_AGING_EN
      test_aging();
`endif
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/hop_cnt_rr_arbiter.md
Name: hop_cnt_rr_arbiter

Overview:
Registered, packet-locking arbiter for a router output port.
- Grants the requesting input with the highest hop count.
- Breaks ties among equal-maximum requesters with a round-robin pointer.
- Holds the grant until the winner's tail flit is transferred.
- Generalises hop-count arbitration to any IN_N. Sits between the input-buffer request lines and the output crossbar select.

Parameters:
IN_N, 5, number of competing inputs (>=2).
HOP_CNT_W, 3, width of each hop-count field.
AGE_W, 4, width of per-input age counter (used only with HOP_ARB_AGING_EN).

Ports:
clk_i  input  1  clock, rising edge.
rst_ni  input  1  asynchronous active-low reset.
req_i  input  IN_N  per-input request (flit valid at input head).
hop_cnt_i  input  IN_N x HOP_CNT_W  per-input hop count of head flit, packed [IN_N-1:0][HOP_CNT_W-1:0].
last_i  input  IN_N  per-input head flit is tail flit.
ready_i  input  1  output port accepts a flit this cycle.
gnt_o  output  IN_N  one-hot grant, registered.
gnt_vld_o  output  1  OR of gnt_o, registered.
gnt_idx_o  output  $clog2(IN_N)  binary index of granted input, registered.
tie_o  output  1  registered; high if the last arbitration had >1 candidate at max hop count.

Behaviour:
Reset values (rst_ni low, asynchronous):
- gnt_o=0, gnt_vld_o=0, gnt_idx_o=0, tie_o=0.
- rr_ptr=0; state=IDLE; age counters=0.

Candidates and maximum:
- Masked hop: hop_m[i] = req_i[i] ? hop_cnt_i[i] : 0.
- max = maximum of hop_m over all IN_N inputs.
- Implement max as a parametric loop or tree; no hard-coded input count.
- cand[i] = req_i[i] && hop_m[i]==max. An input requesting with hop 0 is still a candidate when max==0.

Winner selection:
- Winner is the first cand index at or after rr_ptr, scanning upward with wrap modulo IN_N.
- Selection is combinational from inputs; grant is registered.

FSM IDLE:
- If |req_i: load gnt_o=onehot(winner), gnt_idx_o=winner, gnt_vld_o=1.
- Same edge: tie_o=(popcount(cand)>1). Go to LOCKED.
- Latency: request to grant is 1 cycle.
- If no request: outputs stay 0; tie_o holds its previous value.

FSM LOCKED:
- Grant frozen regardless of other req_i or hop_cnt_i changes.
- Transfer = req_i[gnt_idx_o] && ready_i.
- Transfer with last_i[gnt_idx_o]=1: clear gnt_o/gnt_vld_o next edge, rr_ptr = (gnt_idx_o+1) mod IN_N, go to IDLE.
- Transfer without last: stay LOCKED.
- Granted req_i dropping mid-packet: stay LOCKED (grant held, no transfer).

Boundary conditions:
- One idle bubble between packets: re-arbitration happens in the IDLE cycle after release.
- Single-flit packet: req+last+ready in the first LOCKED cycle gives a grant lasting exactly 1 cycle.
- rr_ptr wraps from IN_N-1 to 0.
- rr_ptr advances only on packet release, never on single flits.
- Reset mid-packet drops the grant immediately (asynchronously); the packet is abandoned.
- gnt_o is never multi-hot.

Optional Feature:
Macro HOP_ARB_AGING_EN: starvation protection.

When defined:
- Each input has a saturating AGE_W counter.
- Counter increments on every IDLE arbitration where req_i[i]=1 and i is not the winner.
- Counter clears when input i is granted or when req_i[i]=0.
- Any input with age == 2^AGE_W-1 is an aged candidate.
- If any aged candidates exist, they replace cand, ignoring hop count; the round-robin scan still applies among them.
- tie_o then reflects popcount of the aged set.

When undefined:
- No counters are instantiated; selection is purely hop-count plus round-robin.

Test Plan:
1. Reset, IN_N=5. req_i=5'b10110, hop={4:3,2:6,1:2}. Response: next edge gnt_o=5'b00100, gnt_idx_o=2, tie_o=0.
2. Tie: req_i=5'b01010 (inputs 1 and 3), both hop=5, rr_ptr=0. Response: grant input 1, tie_o=1. After its tail transfers, rr_ptr=2. A repeat of the same request then grants input 3.
3. Locking: grant input 0 on a 4-flit packet; ready_i toggles 1,0,1,1,1; input 4 raises hop=7 mid-packet. Response: gnt_o stays 5'b00001 until the tail transfers; then one IDLE cycle; then grant input 4.
4. Wrap and idle: last winner is input 4 (rr_ptr=0), then req_i=0 for 3 cycles. Response: gnt_vld_o=0 throughout. Then equal hops on inputs 0 and 4: grant input 0.
5. Async reset: assert rst_ni low mid-packet between clock edges. Response: gnt_o=0 and gnt_vld_o=0 immediately. After release, re-arbitration starts from rr_ptr=0.
6. Aging (HOP_ARB_AGING_EN, AGE_W=2): input 0 at hop=1 continuously vs. a stream of hop=7 single-flit packets on inputs 1 and 2. Response: input 0 is granted on its 4th arbitration (age reaches 3); its age then clears.
